rtc_bus_ctrl: RTL and testbench
===============================

# rtc_bus_ctrl

Bus-cycle engine that sits directly downstream of the chronometer/clock sequencers (the reset-sequencing stage and its siblings). It turns one-cycle register read/write requests (8-bit address, 8-bit data) into a complete multiplexed address/data bus transaction on the external RTC. It generates CS/AD/RD/WR strobes with programmable pulse and gap widths, captures read data, and reports completion with a single-cycle `done` pulse.

## Interface

- `T_PULSE`, default 10: strobe-low width in clk cycles (100 ns at 100 MHz). Legal range 1..255.
- `T_GAP`, default 10: strobes-high recovery width in clk cycles after each strobe. Legal range 1..255.

- `clk` in 1: system clock; the block uses this single clock.
- `reset` in 1: synchronous, active-high reset.
- `req_wr` in 1: write request, sampled only in IDLE.
- `req_rd` in 1: read request, sampled only in IDLE.
- `addr` in 8: RTC register address, latched on acceptance.
- `wdata` in 8: write data, latched on acceptance.
- `busy` out 1: high from the cycle after acceptance through the DONE cycle.
- `done` out 1: one-cycle pulse at the end of each transaction.
- `rdata` out 8: last read data; holds its value until the next read completes.
- `rtc_cs_n` out 1: chip select, active low.
- `rtc_ad_n` out 1: 0 = address phase, 1 = data phase.
- `rtc_rd_n` out 1: read strobe, active low.
- `rtc_wr_n` out 1: write strobe, active low.
- `ad_out` out 8: value driven onto the AD bus.
- `ad_oe` out 1: AD bus output enable. The tristate buffer is instantiated at top level.
- `ad_in` in 8: AD bus input.

## Operation

- States: IDLE, A_STB, A_GAP, D_STB, D_GAP, DONE. An 8-bit down-counter `cnt` times A_STB, A_GAP, D_STB and D_GAP.
- IDLE: all strobes high, `ad_oe`=0, `busy`=0.
  - If `req_wr` or `req_rd` is high, latch `addr`, `wdata` and the direction, load `cnt`=T_PULSE-1, and go to A_STB.
  - If both requests are high in the same cycle, the write wins and the read is dropped.
- A_STB: `rtc_cs_n`=0, `rtc_ad_n`=0, `rtc_wr_n`=0, `ad_oe`=1, `ad_out`=latched addr.
  - On `cnt`=0, load T_GAP-1 and go to A_GAP.
- A_GAP: all strobes high, `rtc_ad_n`=0, `ad_oe`=1, `ad_out`=addr (address hold).
  - On `cnt`=0, load T_PULSE-1 and go to D_STB.
- D_STB: `rtc_cs_n`=0, `rtc_ad_n`=1.
  - Write: `rtc_wr_n`=0, `ad_oe`=1, `ad_out`=latched wdata.
  - Read: `rtc_rd_n`=0, `ad_oe`=0, and `rdata` <= `ad_in` on the edge where `cnt`=0.
  - On `cnt`=0, load T_GAP-1 and go to D_GAP.
- D_GAP: all strobes high, `rtc_ad_n`=1.
  - `ad_oe`=1 for a write (data hold), 0 for a read.
  - On `cnt`=0, go to DONE.
- DONE: `done`=1, strobes high, `ad_oe`=0. Next state is unconditionally IDLE, so no request is accepted in DONE.
- Requests while `busy`=1 are ignored and not queued. Upstream sequencers must wait for `done`.
- Strobes, `ad_oe` and `ad_out` are registered outputs decoded from the next state, so there are no glitches.
- RD and WR are never low at the same time. `rtc_cs_n` is high whenever both RD and WR are high.

## Timing

- Reset values: `busy`=0, `done`=0, `rdata`=8'h00, `rtc_cs_n`=1, `rtc_ad_n`=1, `rtc_rd_n`=1, `rtc_wr_n`=1, `ad_out`=8'h00, `ad_oe`=0. State is IDLE.
- Acceptance on edge k: the strobes go low and `busy` goes high after edge k.
- Phase widths:
  - A_STB lasts exactly T_PULSE cycles.
  - A_GAP lasts exactly T_GAP cycles.
  - D_STB lasts exactly T_PULSE cycles.
  - D_GAP lasts exactly T_GAP cycles.
- `done` is high for the single cycle after D_GAP. Total latency from acceptance edge to the `done` cycle = 2·T_PULSE + 2·T_GAP cycles.
- `done` goes low on the next edge, together with `busy`. A request presented in that same cycle is accepted one cycle later (minimum request-to-request spacing = 2·T_PULSE + 2·T_GAP + 2 cycles).
- `rdata` updates on the last D_STB edge and is stable before `done` rises.
- Reset mid-transaction: on the reset edge all strobes go high, `ad_oe` goes to 0 and the state returns to IDLE. No `done` is issued and `rdata` clears to 0.
- Counter: T_PULSE=1 or T_GAP=1 gives single-cycle phases. There is no wrap-around because `cnt` is always reloaded before it underflows.

## Test plan

- Write, T_PULSE=T_GAP=10, `addr`=8'h21, `wdata`=8'h5A -> A_STB is 10 cycles with `ad_out`=21, `rtc_wr_n`=0, `rtc_ad_n`=0; D_STB is 10 cycles with `ad_out`=5A, `rtc_wr_n`=0, `rtc_ad_n`=1; `done` comes 40 cycles after acceptance; `rtc_rd_n` stays 1 throughout.
- Read, `addr`=8'h22, `ad_in`=8'h37 during D_STB -> `rtc_rd_n` is low for 10 cycles; `ad_oe`=0 in D_STB and D_GAP; `rdata`=8'h37 at `done`; `rdata` holds 37 after `done`.
- Simultaneous `req_wr`=`req_rd`=1 -> exactly one write transaction, no `rtc_rd_n` pulse, exactly one `done`.
- `req_rd` pulsed mid-write and in the DONE cycle -> both ignored, one `done` only; a new request after `done` is accepted normally.
- `reset` asserted during D_STB of a write -> all strobes 1 and `ad_oe`=0 on the next edge; no `done`; `busy`=0; the next request completes normally.
- T_PULSE=1, T_GAP=1 back-to-back reads to `addr` 8'h01..8'h04 -> each `done` comes 4 cycles after acceptance; every strobe is exactly 1 cycle wide.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: turns single-cycle register read/write requests into a full
// multiplexed address/data bus cycle on the external RTC. The address phase
// always uses the write strobe. The data phase uses WR or RD depending on the
// latched direction. All bus-facing outputs are registered copies of the
// next-state decode, so they change cleanly on clock edges only.
module rtc_bus_ctrl #(
  parameter int T_PULSE = 10,
  parameter int T_GAP   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_wr,
  input  logic       req_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       rtc_cs_n,
  output logic       rtc_ad_n,
  output logic       rtc_rd_n,
  output logic       rtc_wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in
);

  // Counter reload values. Each phase lasts (reload + 1) cycles.
  localparam logic [7:0] PULSE_LD = 8'(T_PULSE - 1);
  localparam logic [7:0] GAP_LD   = 8'(T_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    A_STB,
    A_GAP,
    D_STB,
    D_GAP,
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       is_rd_q, is_rd_d;
  logic [7:0] rdata_q, rdata_d;
  logic       capture;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       cs_n_q, cs_n_d;
  logic       ad_n_q, ad_n_d;
  logic       rd_n_q, rd_n_d;
  logic       wr_n_q, wr_n_d;
  logic       oe_q, oe_d;
  logic [7:0] ad_out_q, ad_out_d;

  // Next-state, phase counter and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    is_rd_d = is_rd_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        // A write wins over a simultaneous read; the read is dropped.
        if (req_wr || req_rd) begin
          addr_d  = addr;
          wdata_d = wdata;
          is_rd_d = ~req_wr;
          cnt_d   = PULSE_LD;
          state_d = A_STB;
        end
      end
      A_STB: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = GAP_LD;
          state_d = A_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      A_GAP: begin
        if (cnt_q == 8'd0) begin
          cnt_d   = PULSE_LD;
          state_d = D_STB;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_STB: begin
        if (cnt_q == 8'd0) begin
          // Sample the bus on the last edge of the read strobe.
          capture = is_rd_q;
          cnt_d   = GAP_LD;
          state_d = D_GAP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      D_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE: begin
        // No acceptance here; the next request is taken from IDLE.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read data register, updated only when a read strobe completes.
  always_comb begin
    rdata_d = rdata_q;
    if (capture) begin
      rdata_d = ad_in;
    end
  end

  // Bus output decode from the next state, registered below.
  always_comb begin
    cs_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    oe_d     = 1'b0;
    ad_out_d = ad_out_q;
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    case (state_d)
      A_STB: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        wr_n_d   = 1'b0;
        oe_d     = 1'b1;
        ad_out_d = addr_d;
      end
      A_GAP: begin
        ad_n_d   = 1'b0;
        oe_d     = 1'b1;
        ad_out_d = addr_d;
      end
      D_STB: begin
        cs_n_d = 1'b0;
        if (is_rd_d) begin
          rd_n_d = 1'b0;
        end else begin
          wr_n_d   = 1'b0;
          oe_d     = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      D_GAP: begin
        if (!is_rd_d) begin
          oe_d     = 1'b1;
          ad_out_d = wdata_d;
        end
      end
      default: begin
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      addr_q   <= 8'h00;
      wdata_q  <= 8'h00;
      is_rd_q  <= 1'b0;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      oe_q     <= 1'b0;
      ad_out_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      is_rd_q  <= is_rd_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      ad_n_q   <= ad_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      oe_q     <= oe_d;
      ad_out_q <= ad_out_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rdata    = rdata_q;
  assign rtc_cs_n = cs_n_q;
  assign rtc_ad_n = ad_n_q;
  assign rtc_rd_n = rd_n_q;
  assign rtc_wr_n = wr_n_q;
  assign ad_oe    = oe_q;
  assign ad_out   = ad_out_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench for rtc_bus_ctrl: one instance with 10/10 timing, one with
// 1/1 timing for single-cycle phases and back-to-back reads.
module tb_rtc_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       a_req_wr, a_req_rd;
  logic [7:0] a_addr, a_wdata, a_ad_in;
  logic       a_busy, a_done, a_cs_n, a_ad_n, a_rd_n, a_wr_n, a_ad_oe;
  logic [7:0] a_rdata, a_ad_out;

  logic       b_req_wr, b_req_rd;
  logic [7:0] b_addr, b_wdata, b_ad_in;
  logic       b_busy, b_done, b_cs_n, b_ad_n, b_rd_n, b_wr_n, b_ad_oe;
  logic [7:0] b_rdata, b_ad_out;

  rtc_bus_ctrl #(.T_PULSE(10), .T_GAP(10)) dut_a (
    .clk(clk), .reset(reset), .req_wr(a_req_wr), .req_rd(a_req_rd),
    .addr(a_addr), .wdata(a_wdata), .busy(a_busy), .done(a_done),
    .rdata(a_rdata), .rtc_cs_n(a_cs_n), .rtc_ad_n(a_ad_n),
    .rtc_rd_n(a_rd_n), .rtc_wr_n(a_wr_n), .ad_out(a_ad_out),
    .ad_oe(a_ad_oe), .ad_in(a_ad_in)
  );

  rtc_bus_ctrl #(.T_PULSE(1), .T_GAP(1)) dut_b (
    .clk(clk), .reset(reset), .req_wr(b_req_wr), .req_rd(b_req_rd),
    .addr(b_addr), .wdata(b_wdata), .busy(b_busy), .done(b_done),
    .rdata(b_rdata), .rtc_cs_n(b_cs_n), .rtc_ad_n(b_ad_n),
    .rtc_rd_n(b_rd_n), .rtc_wr_n(b_wr_n), .ad_out(b_ad_out),
    .ad_oe(b_ad_oe), .ad_in(b_ad_in)
  );

  int total = 0;
  int bad   = 0;

  int n_astb, n_agap, n_dstb, n_dgap, n_rdlow, n_both, n_busy, n_done, n_cslow;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge on instance A.
  task automatic start_a(input logic wr, input logic rd, input logic [7:0] ad, input logic [7:0] wd);
    a_req_wr = wr;
    a_req_rd = rd;
    a_addr   = ad;
    a_wdata  = wd;
    tick();
    a_req_wr = 1'b0;
    a_req_rd = 1'b0;
    $display("txn: req wr=%0b rd=%0b addr=%02h wdata=%02h accepted busy=%0b", wr, rd, ad, wd, a_busy);
  endtask

  // Walk n cycles of an A transaction classifying each cycle by bus phase.
  // Read data is only valid on ad_in during the data strobe (cycles 20..29).
  task automatic observe_a(input int n, input bit is_rd, input logic [7:0] ad, input logic [7:0] d, input int pulse_at);
    n_astb = 0; n_agap = 0; n_dstb = 0; n_dgap = 0;
    n_rdlow = 0; n_both = 0; n_busy = 0; n_done = 0;
    for (int c = 0; c < n; c++) begin
      a_ad_in  = (is_rd && c >= 20 && c < 30) ? d : 8'hEE;
      a_req_rd = (c == pulse_at);
      if (c == pulse_at) a_addr = 8'h77;
      if (!a_cs_n && !a_ad_n && !a_wr_n && a_rd_n && a_ad_oe && a_ad_out == ad) n_astb++;
      if (a_cs_n && !a_ad_n && a_wr_n && a_rd_n && a_ad_oe && a_ad_out == ad) n_agap++;
      if (!is_rd && !a_cs_n && a_ad_n && !a_wr_n && a_rd_n && a_ad_oe && a_ad_out == d) n_dstb++;
      if (is_rd && !a_cs_n && a_ad_n && a_wr_n && !a_rd_n && !a_ad_oe) n_dstb++;
      if (!is_rd && a_cs_n && a_ad_n && a_wr_n && a_rd_n && a_ad_oe && a_ad_out == d) n_dgap++;
      if (is_rd && a_cs_n && a_ad_n && a_wr_n && a_rd_n && !a_ad_oe) n_dgap++;
      if (!a_rd_n) n_rdlow++;
      if (!a_rd_n && !a_wr_n) n_both++;
      if (a_busy) n_busy++;
      if (a_done) n_done++;
      tick();
    end
    a_req_rd = 1'b0;
    a_ad_in  = 8'hEE;
  endtask

  // Check phase counts after a full 40-cycle walk; now at the done cycle.
  task automatic verify_a(input string name, input bit is_rd);
    check({name, "_astb_cycles"}, n_astb, 10);
    check({name, "_agap_cycles"}, n_agap, 10);
    check({name, "_dstb_cycles"}, n_dstb, 10);
    check({name, "_dgap_cycles"}, n_dgap, 10);
    check({name, "_rd_low_cycles"}, n_rdlow, is_rd ? 10 : 0);
    check({name, "_rd_wr_overlap"}, n_both, 0);
    check({name, "_busy_cycles"}, n_busy, 40);
    check({name, "_early_done"}, n_done, 0);
    check({name, "_done_at_40"}, a_done, 1);
    check({name, "_busy_in_done"}, a_busy, 1);
    check({name, "_cs_in_done"}, a_cs_n, 1);
    check({name, "_oe_in_done"}, a_ad_oe, 0);
    $display("txn: %s phases a_stb=%0d a_gap=%0d d_stb=%0d d_gap=%0d done=%0b rdata=%02h",
             name, n_astb, n_agap, n_dstb, n_dgap, a_done, a_rdata);
  endtask

  // Count bus activity on A over n idle cycles.
  task automatic idle_a(input int n);
    n_cslow = 0; n_done = 0; n_busy = 0;
    for (int c = 0; c < n; c++) begin
      if (!a_cs_n) n_cslow++;
      if (a_done) n_done++;
      if (a_busy) n_busy++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_wr = 1'b0; a_req_rd = 1'b0; a_addr = 8'h00; a_wdata = 8'h00; a_ad_in = 8'hEE;
    b_req_wr = 1'b0; b_req_rd = 1'b0; b_addr = 8'h00; b_wdata = 8'h00; b_ad_in = 8'hFF;
    tick();
    tick();

    // Reset state
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rdata", a_rdata, 8'h00);
    check("rst_cs_n", a_cs_n, 1);
    check("rst_ad_n", a_ad_n, 1);
    check("rst_rd_n", a_rd_n, 1);
    check("rst_wr_n", a_wr_n, 1);
    check("rst_ad_out", a_ad_out, 8'h00);
    check("rst_ad_oe", a_ad_oe, 0);
    check("rst_b_cs_n", b_cs_n, 1);
    $display("txn: reset released");
    reset = 1'b0;
    tick();

    // Write 21/5A
    start_a(1'b1, 1'b0, 8'h21, 8'h5A);
    observe_a(40, 1'b0, 8'h21, 8'h5A, -1);
    verify_a("wr21", 1'b0);
    tick();
    check("wr21_done_low", a_done, 0);
    check("wr21_busy_low", a_busy, 0);

    // Read 22, bus returns 37
    start_a(1'b0, 1'b1, 8'h22, 8'h00);
    observe_a(40, 1'b1, 8'h22, 8'h37, -1);
    verify_a("rd22", 1'b1);
    check("rd22_rdata_at_done", a_rdata, 8'h37);
    a_ad_in = 8'h12;
    idle_a(3);
    check("rd22_rdata_hold", a_rdata, 8'h37);

    // Simultaneous write and read: write only
    start_a(1'b1, 1'b1, 8'h30, 8'h99);
    observe_a(40, 1'b0, 8'h30, 8'h99, -1);
    verify_a("both30", 1'b0);
    idle_a(6);
    check("both30_extra_cs", n_cslow, 0);
    check("both30_extra_done", n_done, 1);
    check("both30_rdata_kept", a_rdata, 8'h37);

    // Read pulsed mid-write and in the DONE cycle: both ignored
    start_a(1'b1, 1'b0, 8'h40, 8'h11);
    observe_a(40, 1'b0, 8'h40, 8'h11, 15);
    verify_a("ign40", 1'b0);
    a_req_rd = 1'b1;
    a_addr   = 8'h55;
    tick();
    a_req_rd = 1'b0;
    check("ign40_done_req_busy", a_busy, 0);
    check("ign40_done_req_cs", a_cs_n, 1);
    idle_a(4);
    check("ign40_no_txn", n_busy, 0);
    check("ign40_no_done", n_done, 0);
    start_a(1'b0, 1'b1, 8'h23, 8'h00);
    observe_a(40, 1'b1, 8'h23, 8'hC4, -1);
    verify_a("rd23", 1'b1);
    check("rd23_rdata", a_rdata, 8'hC4);
    tick();

    // Reset during the data strobe of a write
    start_a(1'b1, 1'b0, 8'h50, 8'hAA);
    observe_a(25, 1'b0, 8'h50, 8'hAA, -1);
    check("rst_mid_in_dstb", a_wr_n, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    $display("txn: reset mid-write applied");
    check("rst_mid_cs_n", a_cs_n, 1);
    check("rst_mid_wr_n", a_wr_n, 1);
    check("rst_mid_rd_n", a_rd_n, 1);
    check("rst_mid_ad_oe", a_ad_oe, 0);
    check("rst_mid_busy", a_busy, 0);
    check("rst_mid_done", a_done, 0);
    check("rst_mid_rdata", a_rdata, 8'h00);
    idle_a(20);
    check("rst_mid_no_done", n_done, 0);
    check("rst_mid_no_cs", n_cslow, 0);
    start_a(1'b1, 1'b0, 8'h51, 8'hBB);
    observe_a(40, 1'b0, 8'h51, 8'hBB, -1);
    verify_a("wr51", 1'b0);
    tick();

    // T_PULSE=T_GAP=1: back-to-back reads 01..04, each request presented
    // in the previous DONE cycle and held one more cycle
    b_req_rd = 1'b1;
    b_addr   = 8'h01;
    for (int i = 1; i <= 4; i++) begin
      tick();
      b_req_rd = 1'b0;
      check($sformatf("b%0d_c0_cs", i), b_cs_n, 0);
      check($sformatf("b%0d_c0_wr", i), b_wr_n, 0);
      check($sformatf("b%0d_c0_ad_n", i), b_ad_n, 0);
      check($sformatf("b%0d_c0_ad_out", i), b_ad_out, 8'(i));
      check($sformatf("b%0d_c0_busy", i), b_busy, 1);
      tick();
      check($sformatf("b%0d_c1_cs", i), b_cs_n, 1);
      check($sformatf("b%0d_c1_wr", i), b_wr_n, 1);
      check($sformatf("b%0d_c1_ad_n", i), b_ad_n, 0);
      tick();
      b_ad_in = 8'hA0 + 8'(i);
      check($sformatf("b%0d_c2_rd", i), b_rd_n, 0);
      check($sformatf("b%0d_c2_cs", i), b_cs_n, 0);
      check($sformatf("b%0d_c2_ad_n", i), b_ad_n, 1);
      check($sformatf("b%0d_c2_oe", i), b_ad_oe, 0);
      tick();
      b_ad_in = 8'hFF;
      check($sformatf("b%0d_c3_rd", i), b_rd_n, 1);
      check($sformatf("b%0d_c3_done", i), b_done, 0);
      tick();
      check($sformatf("b%0d_c4_done", i), b_done, 1);
      check($sformatf("b%0d_c4_rdata", i), b_rdata, 8'hA0 + 8'(i));
      $display("txn: b read addr=%02h done=%0b rdata=%02h", 8'(i), b_done, b_rdata);
      if (i < 4) begin
        b_req_rd = 1'b1;
        b_addr   = 8'(i + 1);
        tick();
        check($sformatf("b%0d_after_done_busy", i), b_busy, 0);
        check($sformatf("b%0d_after_done_done", i), b_done, 0);
      end
    end
    tick();
    check("b_final_idle", b_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
